// File: rtl/ece571_cpu_driver.sv
// rtl/ece571_cpu_driver.sv - FIFO-buffered instruction sequencer for the ece571_cpu register/ALU ports
// Optional statistics outputs are enabled by defining ECE571_CPU_DRIVER_STATS_EN.
module ece571_cpu_driver #(
    parameter int DEPTH      = 4,
    parameter int RESULT_LAT = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [1:0]  in_kind,
    input  logic [3:0]  in_rs1,
    input  logic [3:0]  in_rs2,
    input  logic [3:0]  in_rd,
    input  logic [31:0] in_wdata,
    output logic [3:0]  read_addr1,
    output logic [3:0]  read_addr2,
    output logic [3:0]  write_addr,
    output logic [31:0] write_data,
    output logic        we,
    input  logic [31:0] alu_result,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_data,
    output logic [3:0]  rsp_rd,
    output logic        busy
`ifdef ECE571_CPU_DRIVER_STATS_EN
    ,
    output logic [15:0] stat_instr_cnt,
    output logic [15:0] stat_stall_cnt
`endif
);

    localparam int          AW       = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
    localparam logic [2:0]  LAT_INIT = 3'(RESULT_LAT - 1);

    localparam logic [1:0] KIND_WRITE      = 2'b00;
    localparam logic [1:0] KIND_COMPUTE    = 2'b01;
    localparam logic [1:0] KIND_COMPUTE_WB = 2'b10;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_WR    = 3'd1;
    localparam logic [2:0] S_ISSUE = 3'd2;
    localparam logic [2:0] S_RESP  = 3'd3;
    localparam logic [2:0] S_WB    = 3'd4;

    logic [1:0]  kind_mem_q  [DEPTH];
    logic [3:0]  rs1_mem_q   [DEPTH];
    logic [3:0]  rs2_mem_q   [DEPTH];
    logic [3:0]  rd_mem_q    [DEPTH];
    logic [31:0] wdata_mem_q [DEPTH];

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          push, pop;

    logic [1:0]  head_kind;
    logic [3:0]  head_rs1, head_rs2, head_rd;
    logic [31:0] head_wdata;

    logic [2:0]  state_q, state_d;
    logic [2:0]  lat_q, lat_d;
    logic [3:0]  cur_rd_q, cur_rd_d;
    logic        cur_wb_q, cur_wb_d;

    logic [3:0]  read_addr1_q, read_addr1_d;
    logic [3:0]  read_addr2_q, read_addr2_d;
    logic [3:0]  write_addr_q, write_addr_d;
    logic [31:0] write_data_q, write_data_d;
    logic        we_q, we_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic [31:0] rsp_data_q, rsp_data_d;
    logic [3:0]  rsp_rd_q, rsp_rd_d;

    assign in_ready = (count_q != FULL_CNT);
    assign push     = in_valid && in_ready;
    // Pops only happen from IDLE, so at most one instruction is ever in flight.
    assign pop      = (state_q == S_IDLE) && (count_q != '0);

    assign head_kind  = kind_mem_q[rd_ptr_q];
    assign head_rs1   = rs1_mem_q[rd_ptr_q];
    assign head_rs2   = rs2_mem_q[rd_ptr_q];
    assign head_rd    = rd_mem_q[rd_ptr_q];
    assign head_wdata = wdata_mem_q[rd_ptr_q];

    always_ff @(posedge clk) begin
        if (push) begin
            kind_mem_q[wr_ptr_q]  <= in_kind;
            rs1_mem_q[wr_ptr_q]   <= in_rs1;
            rs2_mem_q[wr_ptr_q]   <= in_rs2;
            rd_mem_q[wr_ptr_q]    <= in_rd;
            wdata_mem_q[wr_ptr_q] <= in_wdata;
        end
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_comb begin
        state_d      = state_q;
        lat_d        = lat_q;
        cur_rd_d     = cur_rd_q;
        cur_wb_d     = cur_wb_q;
        read_addr1_d = read_addr1_q;
        read_addr2_d = read_addr2_q;
        write_addr_d = write_addr_q;
        write_data_d = write_data_q;
        we_d         = 1'b0;
        rsp_valid_d  = rsp_valid_q;
        rsp_data_d   = rsp_data_q;
        rsp_rd_d     = rsp_rd_q;

        case (state_q)
            S_IDLE: begin
                if (pop) begin
                    cur_rd_d = head_rd;
                    cur_wb_d = (head_kind == KIND_COMPUTE_WB);
                    case (head_kind)
                        KIND_WRITE: begin
                            write_addr_d = head_rd;
                            write_data_d = head_wdata;
                            we_d         = 1'b1;
                            state_d      = S_WR;
                        end
                        KIND_COMPUTE, KIND_COMPUTE_WB: begin
                            read_addr1_d = head_rs1;
                            read_addr2_d = head_rs2;
                            lat_d        = LAT_INIT;
                            state_d      = S_ISSUE;
                        end
                        default: state_d = S_IDLE;
                    endcase
                end
            end
            S_WR: begin
                state_d = S_IDLE;
            end
            S_ISSUE: begin
                if (lat_q == 3'd0) begin
                    rsp_data_d  = alu_result;
                    rsp_rd_d    = cur_rd_q;
                    rsp_valid_d = 1'b1;
                    state_d     = S_RESP;
                end else begin
                    lat_d = lat_q - 3'd1;
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    if (cur_wb_q) begin
                        write_addr_d = cur_rd_q;
                        write_data_d = rsp_data_q;
                        we_d         = 1'b1;
                        state_d      = S_WB;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            S_WB: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            state_q      <= S_IDLE;
            lat_q        <= 3'd0;
            cur_rd_q     <= 4'd0;
            cur_wb_q     <= 1'b0;
            read_addr1_q <= 4'd0;
            read_addr2_q <= 4'd0;
            write_addr_q <= 4'd0;
            write_data_q <= 32'd0;
            we_q         <= 1'b0;
            rsp_valid_q  <= 1'b0;
            rsp_data_q   <= 32'd0;
            rsp_rd_q     <= 4'd0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            state_q      <= state_d;
            lat_q        <= lat_d;
            cur_rd_q     <= cur_rd_d;
            cur_wb_q     <= cur_wb_d;
            read_addr1_q <= read_addr1_d;
            read_addr2_q <= read_addr2_d;
            write_addr_q <= write_addr_d;
            write_data_q <= write_data_d;
            we_q         <= we_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_data_q   <= rsp_data_d;
            rsp_rd_q     <= rsp_rd_d;
        end
    end

    assign read_addr1 = read_addr1_q;
    assign read_addr2 = read_addr2_q;
    assign write_addr = write_addr_q;
    assign write_data = write_data_q;
    assign we         = we_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_data   = rsp_data_q;
    assign rsp_rd     = rsp_rd_q;
    assign busy       = (state_q != S_IDLE) || (count_q != '0);

`ifdef ECE571_CPU_DRIVER_STATS_EN
    logic        instr_done;
    logic [15:0] instr_cnt_q, instr_cnt_d;
    logic [15:0] stall_cnt_q, stall_cnt_d;

    // An instruction retires on leaving WR or WB, or on a plain COMPUTE response handshake.
    assign instr_done = (state_q == S_WR) || (state_q == S_WB) ||
                        ((state_q == S_RESP) && rsp_ready && !cur_wb_q);

    always_comb begin
        instr_cnt_d = instr_cnt_q;
        stall_cnt_d = stall_cnt_q;
        if (instr_done && (instr_cnt_q != 16'hFFFF)) begin
            instr_cnt_d = instr_cnt_q + 16'd1;
        end
        if (rsp_valid_q && !rsp_ready && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            instr_cnt_q <= 16'd0;
            stall_cnt_q <= 16'd0;
        end else begin
            instr_cnt_q <= instr_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stat_instr_cnt = instr_cnt_q;
    assign stat_stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_ece571_cpu_driver.sv
// tb/tb_ece571_cpu_driver.sv - self-checking bench for ece571_cpu_driver with a register-file CPU model
module tb_ece571_cpu_driver;

    localparam int DEPTH      = 4;
    localparam int RESULT_LAT = 3;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  in_kind;
    logic [3:0]  in_rs1, in_rs2, in_rd;
    logic [31:0] in_wdata;
    logic [3:0]  read_addr1, read_addr2, write_addr;
    logic [31:0] write_data;
    logic        we;
    logic [31:0] alu_result;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_data;
    logic [3:0]  rsp_rd;
    logic        busy;
`ifdef ECE571_CPU_DRIVER_STATS_EN
    logic [15:0] stat_instr_cnt, stat_stall_cnt;
`endif

    int checks   = 0;
    int failures = 0;

    typedef struct {
        bit          is_rsp;
        logic [3:0]  addr;
        logic [31:0] data;
    } ev_t;

    ev_t         exp_q[$];
    ev_t         obs_q[$];
    logic [31:0] m_rf   [16];
    logic [31:0] cpu_rf [16];

    ece571_cpu_driver #(.DEPTH(DEPTH), .RESULT_LAT(RESULT_LAT)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_kind(in_kind),
        .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd), .in_wdata(in_wdata),
        .read_addr1(read_addr1), .read_addr2(read_addr2), .write_addr(write_addr),
        .write_data(write_data), .we(we), .alu_result(alu_result),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_rd(rsp_rd), .busy(busy)
`ifdef ECE571_CPU_DRIVER_STATS_EN
        , .stat_instr_cnt(stat_instr_cnt), .stat_stall_cnt(stat_stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    // CPU stand-in: register file written by we, ALU adds the two read ports.
    always @(posedge clk) if (we) cpu_rf[write_addr] <= write_data;
    assign alu_result = cpu_rf[read_addr1] + cpu_rf[read_addr2];

    always @(negedge clk) begin
        if (we) obs_q.push_back('{1'b0, write_addr, write_data});
        if (rsp_valid && rsp_ready) obs_q.push_back('{1'b1, rsp_rd, rsp_data});
    end

    function automatic void model_push(input logic [1:0] k, input logic [3:0] s1, input logic [3:0] s2,
                                       input logic [3:0] d, input logic [31:0] wd);
        logic [31:0] r;
        r = m_rf[s1] + m_rf[s2];
        case (k)
            2'b00: begin m_rf[d] = wd; exp_q.push_back('{1'b0, d, wd}); end
            2'b01: exp_q.push_back('{1'b1, d, r});
            2'b10: begin exp_q.push_back('{1'b1, d, r}); exp_q.push_back('{1'b0, d, r}); m_rf[d] = r; end
            default: ;
        endcase
    endfunction

    task automatic push_instr(input logic [1:0] k, input logic [3:0] s1, input logic [3:0] s2,
                              input logic [3:0] d, input logic [31:0] wd, input bit use_model);
        logic rdy;
        int   cyc;
        @(posedge clk); #1;
        in_kind = k; in_rs1 = s1; in_rs2 = s2; in_rd = d; in_wdata = wd; in_valid = 1'b1;
        cyc = 0;
        do begin
            @(negedge clk); rdy = in_ready;
            @(posedge clk); #1; cyc++;
        end while (!rdy && cyc < 100);
        in_valid = 1'b0;
        if (!rdy) begin
            checks++; failures++;
            $display("FAIL push_timeout got in_ready=%0b want 1 within 100 cycles", rdy);
        end else if (use_model) begin
            model_push(k, s1, s2, d, wd);
        end
    endtask

    task automatic wait_idle;
        for (int c = 0; c < 200 && busy; c++) @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin failures++; $display("FAIL idle_timeout busy=%0b want 0", busy); end
    endtask

    task automatic test_reset;
        reset = 1'b0; in_valid = 1'b1; in_kind = 2'b00; in_rs1 = 4'd0; in_rs2 = 4'd0;
        in_rd = 4'd2; in_wdata = 32'hA5A5A5A5; rsp_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL rst_in_ready got %0b want 1", in_ready); end
        checks++; if (we !== 1'b0) begin failures++; $display("FAIL rst_we got %0b want 0", we); end
        checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL rst_rsp_valid got %0b want 0", rsp_valid); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rst_busy got %0b want 0", busy); end
        checks++;
        if ({write_addr, write_data, read_addr1, read_addr2, rsp_data, rsp_rd} !== '0) begin
            failures++; $display("FAIL rst_outputs got wa=%h wd=%h ra1=%h ra2=%h rd=%h rr=%h want all 0",
                                 write_addr, write_data, read_addr1, read_addr2, rsp_data, rsp_rd);
        end
        @(posedge clk); #1; reset = 1'b1; in_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++;
            if (we !== 1'b0 || busy !== 1'b0) begin
                failures++; $display("FAIL rst_no_accept cycle %0d got we=%0b busy=%0b want 0 0", i, we, busy);
            end
        end
    endtask

    task automatic test_write;
        push_instr(2'b00, 4'd0, 4'd0, 4'd3, 32'hDEADBEEF, 1'b1);
        @(negedge clk);
        checks++; if (we !== 1'b0) begin failures++; $display("FAIL wr_early got we=%0b want 0", we); end
        @(negedge clk);
        checks++;
        if (we !== 1'b1 || write_addr !== 4'd3 || write_data !== 32'hDEADBEEF) begin
            failures++; $display("FAIL wr_pulse got we=%0b wa=%0d wd=%h want 1 3 deadbeef", we, write_addr, write_data);
        end
        @(negedge clk);
        checks++; if (we !== 1'b0) begin failures++; $display("FAIL wr_single got we=%0b want 0", we); end
        wait_idle();
    endtask

    task automatic test_compute;
        push_instr(2'b00, 4'd0, 4'd0, 4'd3, 32'h6, 1'b1);
        wait_idle();
        push_instr(2'b00, 4'd0, 4'd0, 4'd5, 32'hA, 1'b1);
        wait_idle();
        rsp_ready = 1'b0;
        push_instr(2'b01, 4'd3, 4'd5, 4'd7, 32'h0, 1'b1);
        @(negedge clk);
        for (int i = 0; i < RESULT_LAT; i++) begin
            @(negedge clk);
            checks++;
            if (read_addr1 !== 4'd3 || read_addr2 !== 4'd5 || rsp_valid !== 1'b0) begin
                failures++; $display("FAIL cmp_issue %0d got ra1=%0d ra2=%0d rv=%0b want 3 5 0", i, read_addr1, read_addr2, rsp_valid);
            end
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if (rsp_valid !== 1'b1 || rsp_data !== 32'h10 || rsp_rd !== 4'd7) begin
                failures++; $display("FAIL cmp_hold %0d got rv=%0b data=%h rd=%0d want 1 10 7", i, rsp_valid, rsp_data, rsp_rd);
            end
        end
        @(posedge clk); #1; rsp_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (rsp_valid !== 1'b1 || rsp_data !== 32'h10) begin
            failures++; $display("FAIL cmp_handshake got rv=%0b data=%h want 1 10", rsp_valid, rsp_data);
        end
        @(posedge clk); #1; rsp_ready = 1'b0;
        @(negedge clk);
        checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL cmp_release got rv=%0b want 0", rsp_valid); end
        wait_idle();
    endtask

    task automatic test_wb_raw;
        int we_cyc, ra_cyc, nrsp;
        logic [31:0] we_data, last_data;
        logic [3:0]  last_rd;
        we_cyc = -1; ra_cyc = -1; nrsp = 0; we_data = '0; last_data = '0; last_rd = '0;
        rsp_ready = 1'b1;
        push_instr(2'b10, 4'd3, 4'd5, 4'd9, 32'h0, 1'b1);
        push_instr(2'b01, 4'd9, 4'd3, 4'd1, 32'h0, 1'b1);
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            if (we && write_addr == 4'd9 && we_cyc < 0) begin we_cyc = c; we_data = write_data; end
            if (read_addr1 == 4'd9 && ra_cyc < 0) ra_cyc = c;
            if (rsp_valid && rsp_ready) begin nrsp++; last_data = rsp_data; last_rd = rsp_rd; end
        end
        checks++;
        if (we_cyc < 0 || we_data !== 32'h10) begin
            failures++; $display("FAIL wb_pulse got cyc=%0d data=%h want pulse with 10", we_cyc, we_data);
        end
        checks++;
        if (ra_cyc <= we_cyc) begin
            failures++; $display("FAIL wb_raw_order got ra1_cyc=%0d we_cyc=%0d want ra1 after we", ra_cyc, we_cyc);
        end
        checks++;
        if (nrsp != 2 || last_data !== 32'h16 || last_rd !== 4'd1) begin
            failures++; $display("FAIL wb_second got n=%0d data=%h rd=%0d want 2 16 1", nrsp, last_data, last_rd);
        end
        wait_idle();
    endtask

    task automatic test_back_to_back;
        int   n, cyc;
        logic rdy;
        obs_q.delete(); exp_q.delete();
        rsp_ready = 1'b0; n = 0; cyc = 0;
        @(posedge clk); #1;
        in_kind = 2'b01; in_rs1 = 4'd3; in_rs2 = 4'd0; in_rd = 4'd0; in_wdata = '0; in_valid = 1'b1;
        while (n < 6 && cyc < 200) begin
            @(negedge clk); rdy = in_ready;
            if (n == 5 && cyc < 9) begin
                checks++;
                if (rdy !== 1'b0) begin failures++; $display("FAIL b2b_full got in_ready=%0b want 0 after 5 accepts", rdy); end
            end
            @(posedge clk); #1; cyc++;
            if (n == 5 && cyc == 8) rsp_ready = 1'b1;
            if (rdy) begin
                model_push(in_kind, in_rs1, in_rs2, in_rd, in_wdata);
                n++;
                in_rs1 = 4'(n + 3); in_rs2 = 4'(n); in_rd = 4'(n);
            end
        end
        in_valid = 1'b0; rsp_ready = 1'b1;
        checks++;
        if (n != 6 || cyc < 8) begin failures++; $display("FAIL b2b_accepts got %0d by cycle %0d want 6 after cycle 8", n, cyc); end
        wait_idle();
        checks++;
        if (obs_q.size() != exp_q.size()) begin
            failures++; $display("FAIL b2b_count got %0d events want %0d", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            checks++;
            if (obs_q[i].is_rsp != exp_q[i].is_rsp || obs_q[i].addr !== exp_q[i].addr || obs_q[i].data !== exp_q[i].data) begin
                failures++; $display("FAIL b2b_order[%0d] got %0b/%0d/%h want %0b/%0d/%h", i, obs_q[i].is_rsp,
                                     obs_q[i].addr, obs_q[i].data, exp_q[i].is_rsp, exp_q[i].addr, exp_q[i].data);
            end
        end
    endtask

    task automatic test_random;
        int   acc, cyc;
        logic rdy;
        obs_q.delete(); exp_q.delete();
        acc = 0; cyc = 0;
        @(posedge clk); #1;
        in_valid = 1'b1; in_kind = 2'($urandom); in_rs1 = 4'($urandom); in_rs2 = 4'($urandom);
        in_rd = 4'($urandom); in_wdata = $urandom; rsp_ready = 1'b1;
        while (acc < 150 && cyc < 20000) begin
            @(negedge clk); rdy = in_ready;
            @(posedge clk); #1; cyc++;
            if (in_valid && rdy) begin
                model_push(in_kind, in_rs1, in_rs2, in_rd, in_wdata);
                acc++;
            end
            in_valid = ($urandom_range(0, 2) != 0);
            in_kind = 2'($urandom); in_rs1 = 4'($urandom); in_rs2 = 4'($urandom);
            in_rd = 4'($urandom); in_wdata = $urandom;
            rsp_ready = ($urandom_range(0, 3) != 0);
        end
        in_valid = 1'b0; rsp_ready = 1'b1;
        checks++;
        if (acc != 150) begin failures++; $display("FAIL rnd_accepts got %0d want 150", acc); end
        wait_idle();
        checks++;
        if (obs_q.size() != exp_q.size()) begin
            failures++; $display("FAIL rnd_count got %0d events want %0d", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            checks++;
            if (obs_q[i].is_rsp != exp_q[i].is_rsp || obs_q[i].addr !== exp_q[i].addr || obs_q[i].data !== exp_q[i].data) begin
                failures++; $display("FAIL rnd_event[%0d] got %0b/%0d/%h want %0b/%0d/%h", i, obs_q[i].is_rsp,
                                     obs_q[i].addr, obs_q[i].data, exp_q[i].is_rsp, exp_q[i].addr, exp_q[i].data);
            end
        end
    endtask

    task automatic test_reset_abort;
        int c;
        rsp_ready = 1'b0;
        push_instr(2'b10, 4'd3, 4'd5, 4'd9, 32'h0, 1'b0);
        push_instr(2'b00, 4'd0, 4'd0, 4'd4, 32'h12345678, 1'b0);
        for (c = 0; c < 50 && !rsp_valid; c++) @(negedge clk);
        checks++;
        if (rsp_valid !== 1'b1) begin failures++; $display("FAIL abort_resp got rv=%0b want 1", rsp_valid); end
        @(posedge clk); #1; reset = 1'b0;
        @(posedge clk); #1; reset = 1'b1; rsp_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (rsp_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
            failures++; $display("FAIL abort_state got rv=%0b in_ready=%0b busy=%0b want 0 1 0", rsp_valid, in_ready, busy);
        end
`ifdef ECE571_CPU_DRIVER_STATS_EN
        checks++;
        if (stat_instr_cnt !== 16'd0 || stat_stall_cnt !== 16'd0) begin
            failures++; $display("FAIL abort_stats got %0d %0d want 0 0", stat_instr_cnt, stat_stall_cnt);
        end
`endif
        for (int i = 0; i < 10; i++) begin
            checks++;
            if (we !== 1'b0 || busy !== 1'b0) begin
                failures++; $display("FAIL abort_quiet cycle %0d got we=%0b busy=%0b want 0 0", i, we, busy);
            end
            @(negedge clk);
        end
    endtask

    initial begin
        for (int i = 0; i < 16; i++) begin m_rf[i] = 32'd0; cpu_rf[i] = 32'd0; end
        test_reset();
        test_write();
        test_compute();
        test_wb_raw();
        test_back_to_back();
        test_random();
        test_reset_abort();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
